// File: rtl/uart_mmio_ctrl.sv
// UART MMIO controller: TX FIFO + start/busy sequencer, RX capture, status/clear.
// Optional UART_IRQ_EN adds IRQ_MASK at +0x10 and a registered irq output.
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0024,
    parameter int          TX_DEPTH  = 4,
    parameter int          DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              sel,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_strobe,
    output logic              irq
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_IRQ_EN
    localparam logic [31:0] LAST = 32'h10;
`else
    localparam logic [31:0] LAST = 32'hC;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [TX_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;

    logic [DATA_W-1:0] rx_buf;
    logic              rx_ready;
    logic              rx_overrun;
    logic              tx_drop;

    logic [31:0]       off;
    logic [2:0]        idx;
    logic              we;
    logic              re;
    logic              wr_tx;
    logic              wr_clr;
    logic              push;
    logic              pop;
    logic              drop;
    logic              tx_full;
    logic              tx_active;
    logic [31:0]       status;
    logic              unused_ok;

    // Unsigned subtract folds "below base" into a huge offset.
    assign off = addr - BASE_ADDR;
    assign idx = off[4:2];
    assign sel = (addr[1:0] == 2'b00) && (off <= LAST);

    assign we     = sel && wr_en;
    assign re     = sel && rd_en;
    assign wr_tx  = we && (idx == 3'd0);
    assign wr_clr = we && (idx == 3'd3);

    assign tx_full   = (count == CW'(TX_DEPTH));
    assign tx_active = (state != IDLE) || (count != '0);

    assign pop  = (state == IDLE) && (count != '0) && !tx_busy;
    assign push = wr_tx && (!tx_full || pop);
    assign drop = wr_tx && !push;

    assign unused_ok = ^wr_data[31:DATA_W];

    // Full + pop: the freed head slot is the one the push overwrites.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_byte  <= '0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_byte  <= mem[rptr];
                        tx_start <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A byte arriving with CLEAR wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_buf     <= '0;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (wr_clr) begin
                rx_ready   <= 1'b0;
                rx_overrun <= 1'b0;
                tx_drop    <= 1'b0;
            end else if (drop) begin
                tx_drop <= 1'b1;
            end
            if (rx_strobe) begin
                if (wr_clr || !rx_ready) begin
                    rx_buf   <= rx_data;
                    rx_ready <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_IRQ_EN
    logic [1:0] mask;
    logic       wr_mask;

    assign wr_mask = we && (idx == 3'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask <= wr_data[1:0];
            end
            irq <= (mask[0] && rx_ready) ||
                   (mask[1] && (count == '0) && (state == IDLE));
        end
    end
`else
    assign irq = 1'b0;
`endif

    assign status = {27'd0, tx_drop, rx_overrun, tx_active, tx_full, rx_ready};

    always_comb begin
        rd_data = '0;
        if (re) begin
            unique case (1'b1)
                (idx == 3'd1): rd_data = status;
                (idx == 3'd2): rd_data = 32'(rx_buf);
`ifdef UART_IRQ_EN
                (idx == 3'd4): rd_data = 32'(mask);
`endif
                default:       rd_data = '0;
            endcase
        end
    end

endmodule
